// File: rtl/neuron_mac_ctrl.sv
// Neuron multiply-accumulate sequencer: registers x*w products and drives an external 21-bit accumulator.
// Optional macro NEURON_MAC_SATURATE_EN clamps out-of-range sums instead of wrapping.
module neuron_mac_ctrl #(
  parameter int N_INPUTS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  x_in,
  input  logic [7:0]  w_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [20:0] acc_q,
  output logic [20:0] acc_d,
  output logic        acc_en,
  output logic        acc_reset,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         count;
  logic signed [15:0] p;
  logic               p_valid;
  logic               ovf_q;
  logic               hs;
  logic [21:0]        sum22;
  logic               sum_ovf;
  logic [20:0]        sum_red;

  assign hs = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    acc_reset = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        acc_reset = 1'b1;
        state_nxt = S_MAC;
      end
      S_MAC: begin
        in_ready = 1'b1;
        if (hs && count == 8'(N_INPUTS - 1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  count <= 8'd0;
    else if (state == S_CLEAR) count <= 8'd0;
    else if (hs)              count <= count + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p       <= 16'sd0;
      p_valid <= 1'b0;
    end else begin
      p_valid <= hs;
      if (hs) p <= $signed(x_in) * $signed(w_in);
    end
  end

  // Sum at 22 bits so the true result is always representable; overflow when the top two bits differ.
  assign sum22   = {acc_q[20], acc_q} + {{6{p[15]}}, p};
  assign sum_ovf = sum22[21] ^ sum22[20];

`ifdef NEURON_MAC_SATURATE_EN
  assign sum_red = !sum_ovf ? sum22[20:0] : (sum22[21] ? 21'h100000 : 21'h0FFFFF);
`else
  assign sum_red = sum22[20:0];
`endif

  assign acc_en = p_valid;
  assign acc_d  = p_valid ? sum_red : 21'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   ovf_q <= 1'b0;
    else if (state == S_CLEAR) ovf_q <= 1'b0;
    else if (p_valid && sum_ovf) ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;

endmodule

// File: doc/neuron_mac_ctrl.md
NEURON_MAC_CTRL -- requirements
Module: neuron_mac_ctrl

Interface
REQ-001 Parameter N_INPUTS, default 8: number of input/weight pairs per neuron evaluation; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin one neuron evaluation.
REQ-005 x_in  input  8  signed two's-complement activation.
REQ-006 w_in  input  8  signed two's-complement weight.
REQ-007 in_valid  input  1  x_in/w_in pair valid.
REQ-008 in_ready  output  1  block accepts a pair; a pair transfers on a clk edge with in_valid=1 and in_ready=1.
REQ-009 acc_q  input  21  current value of the downstream 21-bit accumulator register.
REQ-010 acc_d  output  21  next accumulator value, to the register data input.
REQ-011 acc_en  output  1  accumulator load enable.
REQ-012 acc_reset  output  1  accumulator clear request.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse; acc_q holds the final sum in that cycle.
REQ-015 ovf  output  1  sticky overflow flag for the current evaluation.

Function
REQ-016 FSM states: IDLE, CLEAR, MAC, DRAIN, DONE.
REQ-017 IDLE: start=1 -> CLEAR; otherwise stay.
REQ-018 CLEAR, one cycle: acc_reset=1, acc_en=0, pair counter=0, ovf=0; -> MAC.
REQ-019 MAC: in_ready=1; each handshake increments the counter; the handshake that brings the count to N_INPUTS -> DRAIN.
REQ-020 DRAIN, one cycle: in_ready=0; the last product is added; -> DONE.
REQ-021 DONE, one cycle: done=1, in_ready=0, acc_en=0; -> IDLE.
REQ-022 Stage 1: on each handshake, register product p = x_in*w_in (16-bit signed) and p_valid=1; p_valid=0 on cycles without a handshake.
REQ-023 Stage 2 (combinational): acc_en=p_valid; acc_d = acc_q + sign-extended p, formed at 22 bits and reduced to 21 bits per REQ-031/032.
REQ-024 Back-to-back handshakes add one product per cycle with no bubbles; the adder reads acc_q, which was already updated by the previous product.
REQ-025 in_valid gaps: the counter holds, acc_en=0, and in_ready stays 1.
REQ-026 start while busy=1 is ignored.
REQ-027 ovf is set when the 22-bit sum lies outside [-1048576, 1048575] and stays set until the next CLEAR.
REQ-028 acc_reset and acc_en are never high in the same cycle.

Reset
REQ-029 rst=1 forces IDLE, counter=0, p=0, p_valid=0, ovf=0 immediately, regardless of clk.
REQ-030 While in IDLE or under reset, in_ready, acc_en, acc_reset, busy and done are 0, and acc_d is 0. A reset mid-evaluation discards the evaluation; the next start begins with CLEAR.

Configuration
REQ-031 With macro NEURON_MAC_SATURATE_EN defined, an out-of-range sum clamps acc_d to 1048575 (positive overflow) or -1048576 (negative overflow).
REQ-032 Without NEURON_MAC_SATURATE_EN, acc_d is the low 21 bits of the sum (wrap-around); ovf still reports overflow per REQ-027.

Verification
REQ-033 N_INPUTS=8; start at edge 0; pairs x=1, w=1 held valid continuously -> CLEAR in cycle 1, MAC in cycles 2-9, DRAIN in cycle 10, done=1 only in cycle 11 with acc_q=8 and ovf=0.
REQ-034 N_INPUTS=8; x=-128, w=127 for all pairs -> at done, acc_q=-130048 and ovf=0.
REQ-035 N_INPUTS=8; in_valid asserted only on alternate cycles -> result identical to REQ-033, done delayed by 7 cycles, in_ready=1 throughout MAC.
REQ-036 N_INPUTS=70; x=-128, w=-128 for all pairs -> ovf=1 at done; acc_q=1048575 with NEURON_MAC_SATURATE_EN, and -950272 without it.
REQ-037 rst asserted after the 3rd handshake -> all outputs 0 asynchronously and state IDLE; a new start yields acc_reset=1 for one cycle and a correct fresh sum.
REQ-038 start pulsed during MAC -> no effect; exactly one done pulse and the correct sum.
